// File: rtl/life_pkg.sv
// life_pkg: shared FSM states, default B3/S23 rule masks and neighbour counting for the life engine.
package life_pkg;
    typedef enum logic [1:0] {IDLE, PRIME, SWEEP, DONE} state_t;
    localparam logic [8:0] RULE_B_DEF = 9'b000001000;
    localparam logic [8:0] RULE_S_DEF = 9'b000001100;
    localparam int NCNT_W = 4;
    function automatic logic [NCNT_W-1:0] popcount8(input logic [7:0] v);
        popcount8 = '0;
        for (int k = 0; k < 8; k++) popcount8 += NCNT_W'(v[k]);
    endfunction
endpackage

// File: rtl/life_gen_engine_if.sv
// life_gen_engine_if: control handshake and row-memory bus between the life engine and its surroundings.
interface life_gen_engine_if #(parameter int WIDTH = 8, ADDR_W = 3, GEN_W = 16);
    logic start, run, rd_en, wr_en, busy, done, still, extinct, halt;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [WIDTH-1:0] rd_data, wr_data;
    logic [GEN_W-1:0] gen_count;
    modport master(output start, run, rd_data,
                   input rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, gen_count, still, extinct, halt);
    modport slave(input start, run, rd_data,
                  output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, gen_count, still, extinct, halt);
endinterface

// File: rtl/life_row_rule.sv
// life_row_rule: next-generation value of one row from its three-row neighbourhood window.
module life_row_rule import life_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int WRAP = 1,
    parameter logic [8:0] RULE_B = RULE_B_DEF,
    parameter logic [8:0] RULE_S = RULE_S_DEF
) (
    input  logic [WIDTH-1:0] top,
    input  logic [WIDTH-1:0] mid,
    input  logic [WIDTH-1:0] bot,
    output logic [WIDTH-1:0] new_row
);
    logic [WIDTH+1:0] te, me, be;
    // one padding bit each side: ext[i] is column i-1, so ext[0]/ext[WIDTH+1] hold the edge neighbours
    assign te = {WRAP != 0 ? top[0] : 1'b0, top, WRAP != 0 ? top[WIDTH-1] : 1'b0};
    assign me = {WRAP != 0 ? mid[0] : 1'b0, mid, WRAP != 0 ? mid[WIDTH-1] : 1'b0};
    assign be = {WRAP != 0 ? bot[0] : 1'b0, bot, WRAP != 0 ? bot[WIDTH-1] : 1'b0};
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic [NCNT_W-1:0] n;
        assign n = popcount8({te[i], te[i+1], te[i+2], me[i], me[i+2], be[i], be[i+1], be[i+2]});
        assign new_row[i] = me[i+1] ? RULE_S[n] : RULE_B[n];
    end
endmodule

// File: rtl/life_gen_engine.sv
// life_gen_engine: sweeps a row memory once per generation, rewriting each row in place through a 3-row window.
module life_gen_engine import life_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int GEN_W = 16,
    parameter int WRAP = 1,
    parameter logic [8:0] RULE_B = RULE_B_DEF,
    parameter logic [8:0] RULE_S = RULE_S_DEF
) (
    input logic ph1,
    input logic reset,
    life_gen_engine_if.slave bus
);
    state_t state, nstate;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W:0] r2;
    logic [WIDTH-1:0] top, mid, bot, row0_save, new_row;
    logic [GEN_W-1:0] gen_count;
    logic chg, live, nchg, nlive, still, extinct, halt, go, last;
    life_row_rule #(.WIDTH(WIDTH), .WRAP(WRAP), .RULE_B(RULE_B), .RULE_S(RULE_S)) u_rule (
        .top(top), .mid(mid), .bot(bot), .new_row(new_row)
    );
    assign last = state == SWEEP && cnt == ADDR_W'(DEPTH - 1);
    // the last row's lower neighbour is row 0, already overwritten in memory, hence the saved copy
    assign bot = last ? (WRAP != 0 ? row0_save : '0) : bus.rd_data;
    assign nchg = chg | (new_row != mid);
    assign nlive = live | (|new_row);
    assign bus.wr_data = state == SWEEP ? new_row : '0;
    assign bus.gen_count = gen_count;
    assign bus.still = still;
    assign bus.extinct = extinct;
    assign bus.halt = halt;
    always_comb begin
        r2 = {1'b0, cnt} + (ADDR_W+1)'(2);
        go = bus.start | (bus.run & ~halt);
        nstate = state == IDLE  ? (go ? PRIME : IDLE)
               : state == PRIME ? (cnt == ADDR_W'(2) ? SWEEP : PRIME)
               : state == SWEEP ? (last ? DONE : SWEEP)
               : (bus.run & ~halt ? PRIME : IDLE);
        bus.rd_en = state == PRIME || (state == SWEEP && r2 < (ADDR_W+1)'(DEPTH));
        bus.rd_addr = state == PRIME ? (cnt == '0 ? ADDR_W'(DEPTH - 1) : cnt - 1'b1)
                    : bus.rd_en ? r2[ADDR_W-1:0] : '0;
        bus.wr_en = state == SWEEP;
        bus.wr_addr = state == SWEEP ? cnt : '0;
        bus.busy = state == PRIME || state == SWEEP;
        bus.done = state == DONE;
    end
    always_ff @(posedge ph1) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            top <= '0;
            mid <= '0;
            row0_save <= '0;
            chg <= 1'b0;
            live <= 1'b0;
            gen_count <= '0;
            still <= 1'b0;
            extinct <= 1'b0;
            halt <= 1'b0;
        end else begin
            state <= nstate;
            cnt <= nstate != state ? '0 : cnt + 1'b1;
            if (state == PRIME && cnt == ADDR_W'(1)) top <= WRAP != 0 ? bus.rd_data : '0;
            if (state == PRIME && cnt == ADDR_W'(2)) begin
                mid <= bus.rd_data;
                row0_save <= bus.rd_data;
            end
            if (state == PRIME) begin
                chg <= 1'b0;
                live <= 1'b0;
            end
            if (state == SWEEP) begin
                top <= mid;
                mid <= bot;
                chg <= nchg;
                live <= nlive;
            end
            // flags land together with the done pulse so DONE can decide on free-run continuation
            if (last) begin
                gen_count <= gen_count + 1'b1;
                still <= ~nchg;
                extinct <= ~nlive;
            end
            halt <= !bus.run || (state == IDLE && bus.start) ? 1'b0
                  : last && (!nchg || !nlive) ? 1'b1 : halt;
        end
    end
endmodule

// File: tb/tb_life_gen_engine.sv
// tb_life_gen_engine: directed scenarios on an 8x8 torus and a 16x12 dead-border board with a board-level reference model.
module tb_life_gen_engine;
    typedef logic [15:0] board_t [12];
    logic ph1 = 1'b0;
    logic reset = 1'b1;
    logic [1:0] ld = 2'b00;
    board_t img = '{default: '0};
    board_t mem0 = '{default: '0};
    board_t mem1 = '{default: '0};
    int n_cmp = 0;
    int n_bad = 0;
    always #5 ph1 = ~ph1;

    life_gen_engine_if #(.WIDTH(8), .ADDR_W(3), .GEN_W(16)) b8();
    life_gen_engine_if #(.WIDTH(16), .ADDR_W(4), .GEN_W(16)) b16();
    life_gen_engine #(.WIDTH(8), .DEPTH(8), .WRAP(1)) u8 (.ph1(ph1), .reset(reset), .bus(b8));
    life_gen_engine #(.WIDTH(16), .DEPTH(12), .WRAP(0)) u16 (.ph1(ph1), .reset(reset), .bus(b16));

    always @(posedge ph1) begin
        if (ld[0]) mem0 <= img;
        else if (b8.wr_en) mem0[b8.wr_addr] <= 16'(b8.wr_data);
        if (b8.rd_en) b8.rd_data <= mem0[b8.rd_addr][7:0];
    end
    always @(posedge ph1) begin
        if (ld[1]) mem1 <= img;
        else if (b16.wr_en) mem1[b16.wr_addr] <= b16.wr_data;
        if (b16.rd_en) b16.rd_data <= mem1[b16.rd_addr];
    end

    logic [1:0] wr_en, done_o, still_o, extinct_o;
    logic [3:0] wr_addr [2];
    logic [15:0] wr_data [2];
    logic [15:0] gen_o [2];
    assign wr_en = {b16.wr_en, b8.wr_en};
    assign done_o = {b16.done, b8.done};
    assign still_o = {b16.still, b8.still};
    assign extinct_o = {b16.extinct, b8.extinct};
    assign wr_addr[0] = {1'b0, b8.wr_addr};
    assign wr_addr[1] = b16.wr_addr;
    assign wr_data[0] = 16'(b8.wr_data);
    assign wr_data[1] = b16.wr_data;
    assign gen_o[0] = b8.gen_count;
    assign gen_o[1] = b16.gen_count;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // B3/S23 applied cell by cell with explicit neighbour offsets
    function automatic board_t step(input board_t b, input int w, input int d, input bit wrap);
        board_t n;
        int cnt, rr, cc;
        n = '{default: '0};
        for (int r = 0; r < d; r++)
            for (int c = 0; c < w; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + d) % d;
                            cc = (cc + w) % w;
                        end
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < d && cc >= 0 && cc < w)
                            cnt += int'(b[rr][cc]);
                    end
                n[r][c] = b[r][c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        return n;
    endfunction

    function automatic bit same(input board_t a, input board_t b);
        for (int r = 0; r < 12; r++) if (a[r] != b[r]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit empty(input board_t a);
        for (int r = 0; r < 12; r++) if (a[r] != '0) return 1'b0;
        return 1'b1;
    endfunction

    board_t cur [2];
    board_t nxt [2];
    int mgen [2] = '{0, 0};
    logic [11:0] wrote [2] = '{12'h0, 12'h0};

    always @(posedge ph1) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int r = 0; r < 12; r++) if (wrote[k][r]) cur[k][r] = nxt[k][r];
                nxt[k] = step(cur[k], k == 0 ? 8 : 16, k == 0 ? 8 : 12, k == 0);
                wrote[k] = '0;
                mgen[k] = 0;
            end else if (ld[k]) begin
                cur[k] = img;
                nxt[k] = step(cur[k], k == 0 ? 8 : 16, k == 0 ? 8 : 12, k == 0);
                wrote[k] = '0;
            end else begin
                if (wr_en[k]) begin
                    chk($sformatf("model_row[%0d][%0d]", k, wr_addr[k]), 32'(wr_data[k]), 32'(nxt[k][wr_addr[k]]));
                    wrote[k][wr_addr[k]] = 1'b1;
                end
                if (done_o[k]) begin
                    mgen[k]++;
                    chk($sformatf("model_rows_written[%0d]", k), 32'(wrote[k]), k == 0 ? 32'h0ff : 32'hfff);
                    chk($sformatf("model_gen[%0d]", k), 32'(gen_o[k]), 32'(16'(mgen[k])));
                    chk($sformatf("model_still[%0d]", k), 32'(still_o[k]), 32'(same(cur[k], nxt[k])));
                    chk($sformatf("model_extinct[%0d]", k), 32'(extinct_o[k]), 32'(empty(nxt[k])));
                    cur[k] = nxt[k];
                    nxt[k] = step(cur[k], k == 0 ? 8 : 16, k == 0 ? 8 : 12, k == 0);
                    wrote[k] = '0;
                end
            end
        end
    end

    task automatic load(input int k, input board_t b);
        @(negedge ph1);
        img = b;
        ld[k] = 1'b1;
        @(negedge ph1);
        ld[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int lim, output int lat);
        lat = -1;
        for (int c = 0; c < lim; c++) begin
            @(posedge ph1);
            #1;
            if (done_o[k]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_gen(input int k, output int lat);
        @(negedge ph1);
        if (k == 0) b8.start = 1'b1; else b16.start = 1'b1;
        @(posedge ph1);
        #1;
        b8.start = 1'b0;
        b16.start = 1'b0;
        wait_done(k, 100, lat);
        lat = lat < 0 ? -1 : lat + 1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        board_t bd;
        int lat, nd, per, lastc, cnt_wr, cnt_busy;
        bit found;
        b8.start = 1'b0;
        b8.run = 1'b0;
        b16.start = 1'b0;
        b16.run = 1'b0;
        repeat (3) @(negedge ph1);
        reset = 1'b0;
        @(posedge ph1);
        #1;
        chk("rst_busy", 32'(b8.busy), 0);
        chk("rst_done", 32'(b8.done), 0);
        chk("rst_wr_en", 32'(b8.wr_en | b16.wr_en), 0);
        chk("rst_rd_en", 32'(b8.rd_en | b16.rd_en), 0);
        chk("rst_gen", 32'(b8.gen_count), 0);
        chk("rst_flags", 32'({b8.still, b8.extinct, b8.halt}), 0);

        // blinker on the torus turns vertical
        bd = '{default: '0};
        bd[3] = 16'h001c;
        load(0, bd);
        run_gen(0, lat);
        chk("blinker_latency", 32'(lat), 11);
        chk("blinker_row2", 32'(mem0[2]), 32'h08);
        chk("blinker_row3", 32'(mem0[3]), 32'h08);
        chk("blinker_row4", 32'(mem0[4]), 32'h08);
        chk("blinker_row5", 32'(mem0[5]), 32'h00);
        chk("blinker_gen", 32'(b8.gen_count), 1);
        chk("blinker_still", 32'(b8.still), 0);

        // block at the dead-border corner is a still life
        bd = '{default: '0};
        bd[0] = 16'h0003;
        bd[1] = 16'h0003;
        load(1, bd);
        run_gen(1, lat);
        chk("block_latency", 32'(lat), 15);
        chk("block_row0", 32'(mem1[0]), 32'h0003);
        chk("block_row1", 32'(mem1[1]), 32'h0003);
        chk("block_still", 32'(b16.still), 1);
        chk("block_extinct", 32'(b16.extinct), 0);

        // isolated corners die; no births across opposite edges
        bd = '{default: '0};
        bd[0] = 16'h8001;
        bd[11] = 16'h8001;
        load(1, bd);
        run_gen(1, lat);
        chk("corner_latency", 32'(lat), 15);
        found = 1'b0;
        for (int r = 0; r < 12; r++) if (mem1[r] != '0) found = 1'b1;
        chk("corner_all_dead", 32'(found), 0);
        chk("corner_extinct", 32'(b16.extinct), 1);
        chk("corner_gen", 32'(b16.gen_count), 2);

        // glider on the torus returns home after 32 generations
        @(negedge ph1);
        reset = 1'b1;
        @(negedge ph1);
        reset = 1'b0;
        bd = '{default: '0};
        bd[0] = 16'h02;
        bd[1] = 16'h04;
        bd[2] = 16'h07;
        load(0, bd);
        @(negedge ph1);
        b8.run = 1'b1;
        nd = 0;
        per = 0;
        lastc = 0;
        for (int c = 0; c < 600 && nd < 32; c++) begin
            @(posedge ph1);
            #1;
            if (done_o[0]) begin
                nd++;
                if (nd == 2) per = c - lastc;
                lastc = c;
                if (b8.halt) chk("glider_no_halt", 32'(b8.halt), 0);
                if (nd == 32) b8.run = 1'b0;
            end
        end
        chk("glider_dones", 32'(nd), 32);
        chk("run_period", 32'(per), 12);
        chk("glider_gen", 32'(b8.gen_count), 32);
        chk("glider_halt", 32'(b8.halt), 0);
        repeat (3) @(posedge ph1);
        #1;
        chk("glider_idle", 32'(b8.busy), 0);
        for (int r = 0; r < 8; r++) chk($sformatf("glider_home_row%0d", r), 32'(mem0[r]), 32'(bd[r]));

        // lone cell under free-run dies out and halts the engine
        bd = '{default: '0};
        bd[0] = 16'h01;
        load(0, bd);
        @(negedge ph1);
        b8.run = 1'b1;
        wait_done(0, 40, lat);
        chk("cell_latency", 32'(lat), 11);
        chk("cell_extinct", 32'(b8.extinct), 1);
        chk("cell_halt", 32'(b8.halt), 1);
        chk("cell_gen", 32'(b8.gen_count), 33);
        cnt_wr = 0;
        cnt_busy = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge ph1);
            #1;
            cnt_wr += int'(b8.wr_en);
            cnt_busy += int'(b8.busy);
        end
        chk("halted_no_writes", 32'(cnt_wr), 0);
        chk("halted_no_busy", 32'(cnt_busy), 0);
        chk("halt_held", 32'(b8.halt), 1);
        @(negedge ph1);
        b8.run = 1'b0;
        @(posedge ph1);
        #1;
        chk("halt_cleared", 32'(b8.halt), 0);

        // reset in the middle of a sweep leaves rows 0..4 updated
        bd = '{default: '0};
        bd[3] = 16'h001c;
        load(0, bd);
        @(negedge ph1);
        b8.start = 1'b1;
        @(posedge ph1);
        #1;
        b8.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge ph1);
            #1;
            if (b8.wr_en && b8.wr_addr == 3'd4) begin
                found = 1'b1;
                break;
            end
        end
        chk("sweep_r4_reached", 32'(found), 1);
        @(negedge ph1);
        reset = 1'b1;
        @(posedge ph1);
        #1;
        chk("midrst_wr_en", 32'(b8.wr_en), 0);
        chk("midrst_busy", 32'(b8.busy), 0);
        chk("midrst_gen", 32'(b8.gen_count), 0);
        @(negedge ph1);
        reset = 1'b0;
        chk("midrst_row3", 32'(mem0[3]), 32'h08);
        chk("midrst_row4", 32'(mem0[4]), 32'h08);
        run_gen(0, lat);
        chk("after_rst_latency", 32'(lat), 11);
        chk("after_rst_row3", 32'(mem0[3]), 32'h1c);
        chk("after_rst_row2", 32'(mem0[2]), 32'h00);
        chk("after_rst_gen", 32'(b8.gen_count), 1);

        repeat (2) @(posedge ph1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
